// File: rtl/kmer_filter_pkg.sv
// Shared types, hash seeds and the fold hash for the k-mer filter responder.
package kmer_filter_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    L_RD,
    L_CHK,
    W_RD,
    W_MOD,
    W_WR,
    DONE
  } state_t;

  // Seeds are stored 64 bits wide; only the low KMER_W bits take part in the fold.
  localparam logic [63:0] HASH_SEED [4] = '{
    64'h0000000000000000,
    64'h2545F4914F6CDD1D,
    64'h1B873593CC9E2D51,
    64'h0D6E8FEB86659FD9
  };

  // XOR-fold the low kw bits of x into cw-bit chunks from the LSB up; the top
  // chunk is implicitly zero-padded.
  function automatic logic [31:0] fold_hash(input logic [63:0] x, input int kw, input int cw);
    logic [31:0] h;
    h = '0;
    for (int j = 0; j < 64; j++) begin
      if (j < kw) h[j % cw] = h[j % cw] ^ x[j];
    end
    return h;
  endfunction

endpackage

// File: rtl/kmer_filter_responder_bitmap_sram.sv
// Single-port Bloom bitmap SRAM, 32-bit words, registered read (latency 1).
module bitmap_sram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  // Write when enabled; the read port always returns the addressed word a cycle later.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/kmer_filter_responder.sv
// K-mer filter responder: exact tag table plus Bloom bitmap, lookup and insert.
//
// state | meaning
// CLEAR | zeroing bitmap words after reset, one per cycle
// IDLE  | waiting for hash / bitmap_write strobe
// L_RD  | lookup: bitmap read issued for current probe
// L_CHK | lookup: probe bit tested
// W_RD  | insert: bitmap read issued for current probe
// W_MOD | insert: probe bit ORed into the read word
// W_WR  | insert: modified word written back
// DONE  | one-cycle completion pulse
module kmer_filter_responder
  import kmer_filter_pkg::*;
#(
  parameter int KMER_W   = 62,
  parameter int BM_AW    = 12,
  parameter int NUM_HASH = 2,
  parameter int TAG_AW   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hash,
  input  logic              bitmap_write,
  input  logic [KMER_W-1:0] kmer_in,
  output logic              present,
  output logic              maybe_present,
  output logic              result_valid,
  output logic              write_done,
  output logic              busy,
  output logic              req_dropped
);

  localparam int HW = BM_AW + 5;
  localparam logic [1:0] LAST_PROBE = 2'(NUM_HASH - 1);

  state_t               r_state;
  logic [BM_AW-1:0]     r_clr_addr;
  logic [1:0]           r_probe;
  logic [HW-1:0]        r_hash [4];
  logic [31:0]          r_wdata;
  logic [KMER_W-1:0]    r_tag_kmer [2**TAG_AW];
  logic [2**TAG_AW-1:0] r_tag_vld;
  logic                 r_present;
  logic                 r_maybe;
  logic                 r_result_valid;
  logic                 r_write_done;
  logic                 r_busy;
  logic                 r_req_dropped;

  logic [TAG_AW-1:0]    w_tag_idx;
  logic                 w_tag_hit;
  logic [HW-1:0]        w_cur_hash;
  logic [BM_AW-1:0]     w_probe_addr;
  logic [4:0]           w_probe_bit;
  logic [31:0]          w_rdata;
  logic                 w_bit_set;
  logic                 w_sram_we;
  logic [BM_AW-1:0]     w_sram_addr;
  logic [31:0]          w_sram_wdata;
  logic                 w_drop;
  logic                 w_accept;

  assign w_tag_idx    = kmer_in[TAG_AW-1:0];
  assign w_tag_hit    = r_tag_vld[w_tag_idx] && (r_tag_kmer[w_tag_idx] == kmer_in);
  assign w_cur_hash   = r_hash[r_probe];
  assign w_probe_addr = w_cur_hash[HW-1:5];
  assign w_probe_bit  = w_cur_hash[4:0];
  assign w_bit_set    = w_rdata[w_probe_bit];
  assign w_accept     = (r_state == IDLE) && (hash || bitmap_write);

  // Any strobe outside IDLE is dropped; a hash colliding with bitmap_write in IDLE loses.
  assign w_drop = (r_state != IDLE) ? (hash || bitmap_write) : (hash && bitmap_write);

  assign w_sram_we    = (r_state == CLEAR) || (r_state == W_WR);
  assign w_sram_addr  = (r_state == CLEAR) ? r_clr_addr : w_probe_addr;
  assign w_sram_wdata = (r_state == CLEAR) ? 32'h0 : r_wdata;

  bitmap_sram #(.AW(BM_AW)) u_bitmap (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (w_sram_wdata),
    .o_rdata (w_rdata)
  );

  // Datapath registers without reset: probe hashes, RMW word, tag payload.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 4; i++) begin
        r_hash[i] <= HW'(fold_hash(64'(kmer_in) ^ HASH_SEED[i], KMER_W, HW));
      end
    end
    if (r_state == W_MOD) r_wdata <= w_rdata | (32'h1 << w_probe_bit);
    if (!rst && (r_state == IDLE) && bitmap_write) r_tag_kmer[w_tag_idx] <= kmer_in;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= CLEAR;
      r_clr_addr     <= '0;
      r_probe        <= '0;
      r_tag_vld      <= '0;
      r_present      <= 1'b0;
      r_maybe        <= 1'b0;
      r_result_valid <= 1'b0;
      r_write_done   <= 1'b0;
      r_busy         <= 1'b1;
      r_req_dropped  <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_write_done   <= 1'b0;
      r_req_dropped  <= w_drop;
      case (r_state)
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (&r_clr_addr) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          r_probe <= '0;
          if (bitmap_write) begin
            r_tag_vld[w_tag_idx] <= 1'b1;
            r_state              <= W_RD;
            r_busy               <= 1'b1;
          end else if (hash) begin
            r_busy <= 1'b1;
            if (w_tag_hit) begin
              r_state        <= DONE;
              r_present      <= 1'b1;
              r_maybe        <= 1'b1;
              r_result_valid <= 1'b1;
            end else begin
              r_state   <= L_RD;
              r_present <= 1'b0;
              r_maybe   <= 1'b0;
            end
          end
        end
        L_RD: r_state <= L_CHK;
        L_CHK: begin
          if (!w_bit_set) begin
            r_state        <= DONE;
            r_present      <= 1'b0;
            r_maybe        <= 1'b0;
            r_result_valid <= 1'b1;
          end else if (r_probe == LAST_PROBE) begin
            r_state        <= DONE;
            r_maybe        <= 1'b1;
            r_result_valid <= 1'b1;
          end else begin
            r_probe <= r_probe + 2'd1;
            r_state <= L_RD;
          end
        end
        W_RD:  r_state <= W_MOD;
        W_MOD: r_state <= W_WR;
        W_WR: begin
          if (r_probe == LAST_PROBE) begin
            r_state      <= DONE;
            r_write_done <= 1'b1;
          end else begin
            r_probe <= r_probe + 2'd1;
            r_state <= W_RD;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign present       = r_present;
  assign maybe_present = r_maybe;
  assign result_valid  = r_result_valid;
  assign write_done    = r_write_done;
  assign busy          = r_busy;
  assign req_dropped   = r_req_dropped;

endmodule
